// File: rtl/spi_frame_master_pkg.sv
// Shared types and constants for the 16-bit SPI frame master.
package spi_frame_master_pkg;

    localparam int SPI_WORD_W = 16;
    localparam logic [SPI_WORD_W-1:0] CMD_TOGGLE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_frame_master_clk_divider.sv
// Phase timer: tick_o marks the last sclk cycle of each CLK_DIV-long phase.
module spi_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst,
    input  logic phase_en_i,
    input  logic restart_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = phase_en_i && (cnt_q == 8'(CLK_DIV - 1));
        cnt_d  = cnt_q + 8'd1;
        // Wrapping on the tick lets the next phase start at zero without a restart.
        if (restart_i || !phase_en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI master sending one 16-bit word per frame, MSB first, capturing the echo.
// Optional LOOPBACK_CHECK_EN adds a sticky loop_err output.
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic [SPI_WORD_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  spi_cs,
    input  logic                  spi_miso,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef LOOPBACK_CHECK_EN
    ,
    output logic                  loop_err
`endif
);

    state_e                  state_q, state_d;
    logic [3:0]              bit_q, bit_d;
    logic [7:0]              gap_q, gap_d;
    logic [SPI_WORD_W-1:0]   tx_sr_q, tx_sr_d;
    logic [SPI_WORD_W-1:0]   rx_sr_q, rx_sr_d;
    logic [SPI_WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    spi_clk_q, spi_clk_d;
    logic                    spi_cs_q, spi_cs_d;
    logic                    accept;
    logic                    phase_en;
    logic                    tick;

    assign accept   = tx_valid && (state_q == ST_IDLE);
    assign phase_en = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW);

    spi_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .sclk       (sclk),
        .rst        (rst),
        .phase_en_i (phase_en),
        .restart_i  (accept),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                // Falling edge: capture the echoed bit and present the next one.
                if (tick) begin
                    state_d = ST_LOW;
                    tx_sr_d = {tx_sr_q[SPI_WORD_W-2:0], 1'b0};
                    rx_sr_d = {rx_sr_q[SPI_WORD_W-2:0], spi_miso};
                end
            end
            ST_LOW: begin
                if (tick) begin
                    if (bit_q == 4'd15) begin
                        state_d   = ST_DONE;
                        rx_data_d = rx_sr_q;
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin-level outputs are registered copies of the next-state decode.
        spi_clk_d  = (state_d == ST_HIGH);
        spi_cs_d   = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);
        rx_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            gap_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_cs_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            spi_clk_q  <= spi_clk_d;
            spi_cs_q   <= spi_cs_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign spi_clk  = spi_clk_q;
    assign spi_cs   = spi_cs_q;
    assign spi_mosi = tx_sr_q[SPI_WORD_W-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef LOOPBACK_CHECK_EN
    logic [SPI_WORD_W-1:0] tx_copy_q;
    logic                  loop_err_q;

    // Compared on the edge into DONE so loop_err rises together with rx_valid.
    always_ff @(posedge sclk) begin
        if (rst) begin
            tx_copy_q  <= '0;
            loop_err_q <= 1'b0;
        end else begin
            if (accept) tx_copy_q <= tx_data;
            if ((state_q == ST_LOW) && (state_d == ST_DONE) && (rx_sr_q != tx_copy_q)) begin
                loop_err_q <= 1'b1;
            end
        end
    end

    assign loop_err = loop_err_q;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench: echo slave, vector table of frames, back-to-back, reset abort, fast instance.
module tb_spi_frame_master;
    import spi_frame_master_pkg::*;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        rst = 1'b1;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, spi_clk, spi_mosi, spi_cs, spi_miso, rx_valid, busy;
    logic [15:0] rx_data;
    logic        force_zero = 1'b0;

    logic [15:0] b_tx_data = '0;
    logic        b_tx_valid = 1'b0;
    logic        b_tx_ready, b_spi_clk, b_spi_mosi, b_spi_cs, b_rx_valid, b_busy;
    logic [15:0] b_rx_data;
    logic        b_miso = 1'b0;
`ifdef LOOPBACK_CHECK_EN
    logic        loop_err, b_loop_err;
`endif

    spi_frame_master dut (
        .sclk(sclk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef LOOPBACK_CHECK_EN
        , .loop_err(loop_err)
`endif
    );

    spi_frame_master #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_b (
        .sclk(sclk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi), .spi_cs(b_spi_cs), .spi_miso(b_miso),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy)
`ifdef LOOPBACK_CHECK_EN
        , .loop_err(b_loop_err)
`endif
    );

    // Slave: latches MOSI on the rising edge and echoes it; keeps only complete 16-bit words.
    logic [15:0] s_sh = '0;
    logic        s_miso = 1'b0;
    logic [15:0] data_store = '0;
    logic        command_bit = 1'b0;
    int          s_cnt = 0;

    always @(posedge spi_clk or negedge spi_cs) begin
        if (!spi_cs) begin
            if (s_cnt == 16) begin
                data_store <= s_sh;
                if (s_sh == CMD_TOGGLE) command_bit <= ~command_bit;
            end
            s_cnt  <= 0;
            s_miso <= 1'b0;
        end else begin
            s_sh   <= {s_sh[14:0], spi_mosi};
            s_miso <= spi_mosi;
            s_cnt  <= s_cnt + 1;
        end
    end
    assign spi_miso = force_zero ? 1'b0 : s_miso;

    always @(posedge b_spi_clk) b_miso <= b_spi_mosi;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tx;
        logic [15:0] exp_rx;
        int          exp_lat;
    } vec_t;
    vec_t vecs[5];

    int          lat, pulses, cs_bad, g, wbad, hi, lo;
    logic [15:0] rx;
    logic        prev;
    logic        exp_cmd;
    int          cyc, acc1, acc2, rv1, rv2, cs_low, ready_leak, rv_seen;
    logic [15:0] rx1, rx2, ds_before;

    // Drives one word and walks the frame; cycle 0 is the acceptance cycle.
    task automatic run_frame(input logic [15:0] w);
        logic p;
        int   gg;
        lat = 0; pulses = 0; cs_bad = 0; gg = 0;
        tx_data = w;
        tx_valid = 1'b1;
        while (!tx_ready && gg < 1000) begin
            @(negedge sclk);
            gg++;
        end
        p = spi_clk;
        @(negedge sclk);
        tx_valid = 1'b0;
        lat = 1;
        while (!rx_valid && lat < 1000) begin
            if (spi_clk && !p) pulses++;
            if (!spi_cs) cs_bad++;
            p = spi_clk;
            @(negedge sclk);
            lat++;
        end
        rx = rx_data;
    endtask

    task automatic wait_idle();
        int gg;
        gg = 0;
        while (!tx_ready && gg < 200) begin
            @(negedge sclk);
            gg++;
        end
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 133};
        vecs[1] = '{16'h5A5A, 16'h5A5A, 133};
        vecs[2] = '{16'h0000, 16'h0000, 133};
        vecs[3] = '{16'h7FFE, 16'h7FFE, 133};
        vecs[4] = '{16'hC001, 16'hC001, 133};

        repeat (3) @(negedge sclk);
        check("rst_cs",       32'(spi_cs),   32'd0);
        check("rst_clk",      32'(spi_clk),  32'd0);
        check("rst_mosi",     32'(spi_mosi), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        @(negedge sclk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].tx);
            $display("frame tx=%h rx=%h lat=%0d pulses=%0d", vecs[i].tx, rx, lat, pulses);
            check("vec_rx_data", 32'(rx), 32'(vecs[i].exp_rx));
            check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            check("vec_pulses", 32'(pulses), 32'd16);
            check("vec_cs_held", 32'(cs_bad), 32'd0);
            check("vec_cs_done", 32'(spi_cs), 32'd0);
            @(negedge sclk);
            check("vec_valid_pulse", 32'(rx_valid), 32'd0);
            check("vec_slave_store", 32'(data_store), 32'(vecs[i].exp_rx));
            wait_idle();
        end

        // Back-to-back: valid held high, word changes after the first acceptance.
        wait_idle();
        tx_data = 16'h0001; tx_valid = 1'b1;
        acc1 = -1; acc2 = -1; rv1 = -1; rv2 = -1; cs_low = 0; ready_leak = 0; rx1 = '0; rx2 = '0;
        for (cyc = 0; cyc < 600 && rv2 < 0; cyc++) begin
            if (acc1 >= 0 && cyc == acc1 + 1) tx_data = 16'h8000;
            if (acc1 >= 0 && cyc > acc1 && acc2 < 0 && !spi_cs) cs_low++;
            if (tx_valid && tx_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end else if (acc1 >= 0 && acc2 < 0 && cyc > acc1 && tx_ready) begin
                ready_leak++;
            end
            if (rx_valid) begin
                if (rv1 < 0) begin rv1 = cyc; rx1 = rx_data; end
                else begin rv2 = cyc; rx2 = rx_data; end
            end
            if (rv2 < 0) @(negedge sclk);
        end
        tx_valid = 1'b0;
        $display("b2b acc1=%0d rv1=%0d acc2=%0d rv2=%0d cs_low=%0d", acc1, rv1, acc2, rv2, cs_low);
        check("b2b_rx1", 32'(rx1), 32'h0001);
        check("b2b_rx2", 32'(rx2), 32'h8000);
        check("b2b_lat1", 32'(rv1 - acc1), 32'd133);
        check("b2b_lat2", 32'(rv2 - acc2), 32'd133);
        // DONE cycle, then GAP_CYCLES of GAP, then the IDLE acceptance cycle.
        check("b2b_accept_after_gap", 32'(acc2 - rv1), 32'd3);
        check("b2b_cs_low", 32'(cs_low), 32'd4);
        check("b2b_no_ready", 32'(ready_leak), 32'd0);
        @(negedge sclk);
        wait_idle();

        // Reset during bit 7 of a frame.
        ds_before = data_store;
        tx_data = 16'hBEEF; tx_valid = 1'b1;
        g = 0;
        while (!tx_ready && g < 200) begin @(negedge sclk); g++; end
        prev = 1'b0; pulses = 0; g = 0;
        do begin
            @(negedge sclk);
            tx_valid = 1'b0;
            g++;
            if (spi_clk && !prev) pulses++;
            prev = spi_clk;
        end while (pulses < 8 && g < 500);
        rst = 1'b1;
        @(negedge sclk);
        check("abort_cs", 32'(spi_cs), 32'd0);
        check("abort_clk", 32'(spi_clk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        rv_seen = 0;
        repeat (200) begin
            @(negedge sclk);
            if (rx_valid) rv_seen++;
        end
        check("abort_no_valid", 32'(rv_seen), 32'd0);
        check("abort_slave_discard", 32'(data_store), 32'(ds_before));
        run_frame(16'h1234);
        $display("after abort rx=%h lat=%0d", rx, lat);
        check("abort_next_rx", 32'(rx), 32'h1234);
        check("abort_next_lat", 32'(lat), 32'd133);
        @(negedge sclk);
        wait_idle();

        // Command word twice toggles the slave command bit twice.
        exp_cmd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run_frame(CMD_TOGGLE);
            exp_cmd = ~exp_cmd;
            @(negedge sclk);
            $display("cmd frame rx=%h store=%h cmd=%b", rx, data_store, command_bit);
            check("cmd_rx", 32'(rx), 32'hFFFF);
            check("cmd_store", 32'(data_store), 32'hFFFF);
            check("cmd_toggle", 32'(command_bit), 32'(exp_cmd));
            wait_idle();
        end

`ifdef LOOPBACK_CHECK_EN
        check("lerr_clear", 32'(loop_err), 32'd0);
        force_zero = 1'b1;
        run_frame(16'h00F0);
        $display("loop_err frame rx=%h loop_err=%b", rx, loop_err);
        check("lerr_rx", 32'(rx), 32'h0000);
        check("lerr_set", 32'(loop_err), 32'd1);
        force_zero = 1'b0;
        repeat (20) @(negedge sclk);
        wait_idle();
        run_frame(16'h00F0);
        check("lerr_sticky", 32'(loop_err), 32'd1);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        check("lerr_rst", 32'(loop_err), 32'd0);
        @(negedge sclk);
`endif

        // Fast instance: CLK_DIV=2, GAP_CYCLES=1, every phase exactly two cycles.
        b_tx_data = 16'h3C96; b_tx_valid = 1'b1;
        g = 0;
        while (!b_tx_ready && g < 200) begin @(negedge sclk); g++; end
        prev = b_spi_clk; hi = 0; lo = 0; wbad = 0; pulses = 0;
        @(negedge sclk);
        b_tx_valid = 1'b0;
        lat = 1;
        while (!b_rx_valid && lat < 500) begin
            if (b_spi_clk) begin
                if (!prev) begin
                    pulses++;
                    if (lo != 2) wbad++;
                end
                hi++;
                lo = 0;
            end else begin
                if (prev && hi != 2) wbad++;
                hi = 0;
                lo++;
            end
            prev = b_spi_clk;
            @(negedge sclk);
            lat++;
        end
        $display("fast frame rx=%h lat=%0d pulses=%0d width_errs=%0d", b_rx_data, lat, pulses, wbad);
        check("fast_rx", 32'(b_rx_data), 32'h3C96);
        check("fast_lat", 32'(lat), 32'd67);
        check("fast_pulses", 32'(pulses), 32'd16);
        check("fast_widths", 32'(wbad), 32'd0);
        repeat (3) @(negedge sclk);
        check("fast_idle", 32'(b_busy), 32'd0);
`ifdef LOOPBACK_CHECK_EN
        check("fast_lerr", 32'(b_loop_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
